// File: rtl/sha3_theta_pkg.sv
// Shared types and theta helpers for the Keccak-f theta pipeline.
// Lanes are carried at the maximum width and narrowed by the caller.
package sha3_theta_pkg;

  localparam int unsigned MaxLaneW      = 64;
  localparam int unsigned LaneIdxW      = 6;
  localparam int unsigned NumLegalLaneW = 7;
  localparam int unsigned LegalLaneW [NumLegalLaneW] = '{1, 2, 4, 8, 16, 32, 64};

  typedef logic [MaxLaneW-1:0] lane_t;
  typedef lane_t [4:0]         plane_t;  // indexed by x
  typedef plane_t [4:0]        state_t;  // indexed by y, then x

  function automatic bit lane_w_legal(int unsigned w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NumLegalLaneW; i++) begin
      if (LegalLaneW[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

  // Rotate left by one within the low w bits; bits at and above w stay zero.
  function automatic lane_t rotl1(lane_t v, int unsigned w);
    lane_t r;
    r = '0;
    for (int unsigned i = 0; i < MaxLaneW; i++) begin
      if (i < w) r[i] = v[LaneIdxW'((i + w - 1) % w)];
    end
    return r;
  endfunction

  function automatic plane_t theta_parity(state_t a);
    plane_t c;
    c = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        c[x] = c[x] ^ a[y][x];
      end
    end
    return c;
  endfunction

  function automatic plane_t theta_d(plane_t c, int unsigned w);
    plane_t d;
    for (int x = 0; x < 5; x++) begin
      d[x] = c[3'((x + 4) % 5)] ^ rotl1(c[3'((x + 1) % 5)], w);
    end
    return d;
  endfunction

  function automatic state_t theta_apply(state_t a, plane_t d);
    state_t r;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[y][x] = a[y][x] ^ d[x];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sha3_theta_slot.sv
// One stallable pipeline register slot with a valid/ready handshake.
// ready_o is the slot's advance condition and never depends on valid_i.
module sha3_theta_slot #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  assign ready_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sha3_theta_flow.sv
// Keccak-f theta step behind a stallable valid/ready pipeline of 1 + ELT_STAGES slots,
// with per-state bypass and a wrapping count of states handed downstream.
module sha3_theta_flow
  import sha3_theta_pkg::*;
#(
  parameter int unsigned LANE_W      = 64,
  parameter int unsigned ELT_STAGES  = 1,
  parameter int unsigned CNT_W       = 16,
  parameter string       LOGIC_STYLE = "basic"
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_bypass,
  input  logic [4:0][LANE_W-1:0] isa,
  input  logic [4:0][LANE_W-1:0] isb,
  input  logic [4:0][LANE_W-1:0] isc,
  input  logic [4:0][LANE_W-1:0] isd,
  input  logic [4:0][LANE_W-1:0] ise,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_bypass,
  output logic [4:0][LANE_W-1:0] osa,
  output logic [4:0][LANE_W-1:0] osb,
  output logic [4:0][LANE_W-1:0] osc,
  output logic [4:0][LANE_W-1:0] osd,
  output logic [4:0][LANE_W-1:0] ose,
  output logic [CNT_W-1:0]       done_cnt
);

  localparam bit          UseXor3 = (LOGIC_STYLE == "xor3");
  localparam int unsigned StW     = 25 * LANE_W;
  localparam int unsigned PlW     = 5 * LANE_W;

  if (!lane_w_legal(LANE_W)) begin : gen_bad_lane_w
    $error("sha3_theta_flow: illegal LANE_W %0d", LANE_W);
  end
  if (ELT_STAGES > 1) begin : gen_bad_elt_stages
    $error("sha3_theta_flow: ELT_STAGES must be 0 or 1, got %0d", ELT_STAGES);
  end
  if (LOGIC_STYLE != "basic" && LOGIC_STYLE != "xor3") begin : gen_bad_logic_style
    $error("sha3_theta_flow: unknown LOGIC_STYLE %s", LOGIC_STYLE);
  end

  typedef logic [4:0][LANE_W-1:0] nplane_t;
  typedef nplane_t [4:0]          nstate_t;

  function automatic state_t widen(nstate_t a);
    state_t r;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) r[y][x][LANE_W-1:0] = a[y][x];
    end
    return r;
  endfunction

  function automatic nplane_t parity_n(nstate_t a);
    plane_t  c;
    nplane_t r;
    c = theta_parity(widen(a));
    for (int x = 0; x < 5; x++) r[x] = c[x][LANE_W-1:0];
    return r;
  endfunction

  function automatic nstate_t theta_step(nstate_t a, nplane_t c);
    state_t  aw, rw;
    plane_t  cw;
    nstate_t r;
    aw = widen(a);
    cw = '0;
    for (int x = 0; x < 5; x++) cw[x][LANE_W-1:0] = c[x];
    if (UseXor3) begin
      // Flat three-input XOR per lane instead of forming D first.
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < 5; x++) begin
          rw[y][x] = aw[y][x] ^ cw[3'((x + 4) % 5)] ^ rotl1(cw[3'((x + 1) % 5)], LANE_W);
        end
      end
    end else begin
      rw = theta_apply(aw, theta_d(cw, LANE_W));
    end
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) r[y][x] = rw[y][x][LANE_W-1:0];
    end
    return r;
  endfunction

  nstate_t        in_state, out_state;
  logic           s0_ready;
  logic           last_valid;
  logic [StW:0]   last_data;

  assign in_state = {ise, isd, isc, isb, isa};

  if (ELT_STAGES == 0) begin : gen_single
    logic [StW:0] s0_din;
    assign s0_din = {in_bypass,
                     in_bypass ? in_state : theta_step(in_state, parity_n(in_state))};

    sha3_theta_slot #(
      .Width (StW + 1)
    ) u_slot0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (in_valid),
      .ready_o (s0_ready),
      .data_i  (s0_din),
      .valid_o (last_valid),
      .ready_i (out_ready),
      .data_o  (last_data)
    );
  end else begin : gen_elt
    // Slot 0 carries the raw state plus its column parities C.
    logic [StW+PlW:0] s0_din, s0_dout;
    logic             s0_valid, s1_ready;
    logic             s0_byp;
    nstate_t          s0_state;
    nplane_t          s0_c;
    logic [StW:0]     s1_din;

    assign s0_din = {in_bypass, in_state, parity_n(in_state)};
    assign {s0_byp, s0_state, s0_c} = s0_dout;
    assign s1_din = {s0_byp, s0_byp ? s0_state : theta_step(s0_state, s0_c)};

    sha3_theta_slot #(
      .Width (StW + PlW + 1)
    ) u_slot0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (in_valid),
      .ready_o (s0_ready),
      .data_i  (s0_din),
      .valid_o (s0_valid),
      .ready_i (s1_ready),
      .data_o  (s0_dout)
    );

    sha3_theta_slot #(
      .Width (StW + 1)
    ) u_slot1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (s0_valid),
      .ready_o (s1_ready),
      .data_i  (s1_din),
      .valid_o (last_valid),
      .ready_i (out_ready),
      .data_o  (last_data)
    );
  end

  // Empty slots report ready during reset, so gate explicitly.
  assign in_ready  = s0_ready & rst_n;
  assign out_valid = last_valid;
  assign {out_bypass, out_state} = last_data;
  assign osa = out_state[0];
  assign osb = out_state[1];
  assign osc = out_state[2];
  assign osd = out_state[3];
  assign ose = out_state[4];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = (out_valid && out_ready) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_cnt = cnt_q;

endmodule

// File: tb/tb_sha3_theta_flow.sv
// Directed and randomized checks of sha3_theta_flow against a bench-side theta model.
module tb_sha3_theta_flow;

  typedef logic [4:0][4:0][63:0] st64_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  // Main instance: 64-bit lanes, registered parities.
  logic m_iv, m_ir, m_ib, m_ov, m_or, m_ob;
  st64_t m_in, m_out;
  logic [4:0][63:0] m_osa, m_osb, m_osc, m_osd, m_ose;
  logic [15:0] m_cnt;
  assign m_out = {m_ose, m_osd, m_osc, m_osb, m_osa};

  sha3_theta_flow #(
    .LANE_W(64), .ELT_STAGES(1), .CNT_W(16), .LOGIC_STYLE("basic")
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir), .in_bypass(m_ib),
    .isa(m_in[0]), .isb(m_in[1]), .isc(m_in[2]), .isd(m_in[3]), .ise(m_in[4]),
    .out_valid(m_ov), .out_ready(m_or), .out_bypass(m_ob),
    .osa(m_osa), .osb(m_osb), .osc(m_osc), .osd(m_osd), .ose(m_ose), .done_cnt(m_cnt)
  );

  // Sweep instances: 0:(8,ELT0) 1:(8,ELT1) 2:(1,ELT0) 3:(1,ELT1,xor3), all CNT_W=4.
  logic [3:0] sw_iv, sw_ir, sw_ib, sw_ov, sw_or, sw_ob;
  logic [3:0] sw_cnt [4];
  st64_t sw_in [4];
  logic [4:0][4:0][7:0] n_in0, n_in1, n_out0, n_out1;
  logic [4:0][4:0][0:0] n_in2, n_in3, n_out2, n_out3;
  int sw_w [4] = '{8, 8, 1, 1};

  always_comb begin
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        n_in0[y][x] = sw_in[0][y][x][7:0];
        n_in1[y][x] = sw_in[1][y][x][7:0];
        n_in2[y][x] = sw_in[2][y][x][0:0];
        n_in3[y][x] = sw_in[3][y][x][0:0];
      end
    end
  end

  sha3_theta_flow #(.LANE_W(8), .ELT_STAGES(0), .CNT_W(4), .LOGIC_STYLE("basic")) u_sw0 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]), .in_bypass(sw_ib[0]),
    .isa(n_in0[0]), .isb(n_in0[1]), .isc(n_in0[2]), .isd(n_in0[3]), .ise(n_in0[4]),
    .out_valid(sw_ov[0]), .out_ready(sw_or[0]), .out_bypass(sw_ob[0]),
    .osa(n_out0[0]), .osb(n_out0[1]), .osc(n_out0[2]), .osd(n_out0[3]), .ose(n_out0[4]),
    .done_cnt(sw_cnt[0])
  );
  sha3_theta_flow #(.LANE_W(8), .ELT_STAGES(1), .CNT_W(4), .LOGIC_STYLE("basic")) u_sw1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]), .in_bypass(sw_ib[1]),
    .isa(n_in1[0]), .isb(n_in1[1]), .isc(n_in1[2]), .isd(n_in1[3]), .ise(n_in1[4]),
    .out_valid(sw_ov[1]), .out_ready(sw_or[1]), .out_bypass(sw_ob[1]),
    .osa(n_out1[0]), .osb(n_out1[1]), .osc(n_out1[2]), .osd(n_out1[3]), .ose(n_out1[4]),
    .done_cnt(sw_cnt[1])
  );
  sha3_theta_flow #(.LANE_W(1), .ELT_STAGES(0), .CNT_W(4), .LOGIC_STYLE("basic")) u_sw2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]), .in_bypass(sw_ib[2]),
    .isa(n_in2[0]), .isb(n_in2[1]), .isc(n_in2[2]), .isd(n_in2[3]), .ise(n_in2[4]),
    .out_valid(sw_ov[2]), .out_ready(sw_or[2]), .out_bypass(sw_ob[2]),
    .osa(n_out2[0]), .osb(n_out2[1]), .osc(n_out2[2]), .osd(n_out2[3]), .ose(n_out2[4]),
    .done_cnt(sw_cnt[2])
  );
  sha3_theta_flow #(.LANE_W(1), .ELT_STAGES(1), .CNT_W(4), .LOGIC_STYLE("xor3")) u_sw3 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[3]), .in_ready(sw_ir[3]), .in_bypass(sw_ib[3]),
    .isa(n_in3[0]), .isb(n_in3[1]), .isc(n_in3[2]), .isd(n_in3[3]), .ise(n_in3[4]),
    .out_valid(sw_ov[3]), .out_ready(sw_or[3]), .out_bypass(sw_ob[3]),
    .osa(n_out3[0]), .osb(n_out3[1]), .osc(n_out3[2]), .osd(n_out3[3]), .ose(n_out3[4]),
    .done_cnt(sw_cnt[3])
  );

  function automatic st64_t sw_get_out(int i);
    st64_t r;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        case (i)
          0:       r[y][x][7:0] = n_out0[y][x];
          1:       r[y][x][7:0] = n_out1[y][x];
          2:       r[y][x][0]   = n_out2[y][x];
          default: r[y][x][0]   = n_out3[y][x];
        endcase
      end
    end
    return r;
  endfunction

  // Reference theta on w-bit lanes held in 64-bit containers.
  function automatic st64_t model(st64_t a, bit byp, int w);
    logic [4:0][63:0] c;
    st64_t r;
    logic dbit;
    if (byp) return a;
    c = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) c[x] = c[x] ^ a[y][x];
    end
    r = a;
    for (int x = 0; x < 5; x++) begin
      for (int b = 0; b < w; b++) begin
        dbit = c[(x + 4) % 5][b] ^ c[(x + 1) % 5][(b + w - 1) % w];
        for (int y = 0; y < 5; y++) r[y][x][b] = r[y][x][b] ^ dbit;
      end
    end
    return r;
  endfunction

  function automatic st64_t rand_state(int w);
    st64_t r;
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) r[y][x] = {$urandom, $urandom} & mask;
    end
    return r;
  endfunction

  function automatic int diff_lane(st64_t a, st64_t b);
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        if (a[y][x] !== b[y][x]) return y * 5 + x;
      end
    end
    return 0;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_iv  = 1'b0;
    m_ib  = 1'b0;
    sw_iv = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input st64_t s, input bit b);
    @(negedge clk);
    m_in = s;
    m_ib = b;
    m_iv = 1'b1;
    @(posedge clk);
    #1 m_iv = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_ov && n < 20);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (m_ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", m_ov); end
    checks++; if (m_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt: got %0d expected 0", m_cnt); end
    checks++; if (m_ir !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", m_ir); end
    checks++; if (m_out !== '0 || m_ob !== 1'b0) begin errors++; $display("FAIL reset_outputs: lane %0d got %h expected 0", diff_lane(m_out, '0), m_out[diff_lane(m_out, '0) / 5][diff_lane(m_out, '0) % 5]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (m_ir !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", m_ir); end
  endtask

  task automatic test_zero_state();
    int n;
    apply_reset();
    m_or = 1'b1;
    m_in = '0;
    m_ib = 1'b0;
    m_iv = 1'b1;
    #1;
    checks++; if (m_ir !== 1'b1) begin errors++; $display("FAIL zero_first_accept: got %b expected 1", m_ir); end
    @(posedge clk);
    #1 m_iv = 1'b0;
    wait_out(n);
    checks++; if (n != 2) begin errors++; $display("FAIL zero_latency: got %0d expected 2", n); end
    checks++; if (m_out !== '0 || m_ob !== 1'b0) begin errors++; $display("FAIL zero_data: lane %0d got nonzero expected 0", diff_lane(m_out, '0)); end
    @(negedge clk);
    checks++; if (m_cnt !== 16'd1) begin errors++; $display("FAIL zero_done_cnt: got %0d expected 1", m_cnt); end
    checks++; if (m_ov !== 1'b0) begin errors++; $display("FAIL zero_drained: got %b expected 0", m_ov); end
  endtask

  task automatic test_single_lane(input bit byp);
    st64_t a, exp;
    int n, k;
    apply_reset();
    m_or = 1'b0;
    a = '0;
    a[0][0] = 64'd1;
    exp = '0;
    for (int y = 0; y < 5; y++) begin
      exp[y][1] = 64'd1;
      exp[y][4] = 64'd2;
    end
    exp[0][0] = 64'd1;
    if (byp) exp = a;
    send(a, byp);
    wait_out(n);
    checks++; if (n != 2) begin errors++; $display("FAIL single_latency byp=%0d: got %0d expected 2", byp, n); end
    k = diff_lane(m_out, exp);
    checks++; if (m_out !== exp) begin errors++; $display("FAIL single_data byp=%0d lane %0d: got %h expected %h", byp, k, m_out[k / 5][k % 5], exp[k / 5][k % 5]); end
    checks++; if (m_ob !== byp) begin errors++; $display("FAIL single_bypass: got %b expected %b", m_ob, byp); end
    m_or = 1'b1;
    @(negedge clk);
    checks++; if (m_cnt !== 16'd1) begin errors++; $display("FAIL single_done_cnt: got %0d expected 1", m_cnt); end
  endtask

  task automatic test_stream_stall();
    st64_t st [8], exp [8], snap;
    int sent, recv, k;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      st[i]  = rand_state(64);
      exp[i] = model(st[i], 1'b0, 64);
    end
    sent = 0;
    recv = 0;
    snap = '0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(negedge clk);
      m_or = !(cyc >= 6 && cyc < 11);
      m_iv = (sent < 8);
      m_ib = 1'b0;
      m_in = st[sent < 8 ? sent : 7];
      #1;
      if (cyc == 6) snap = m_out;
      if (cyc >= 6 && cyc < 11) begin
        checks++; if (m_ir !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d: got %b expected 0", cyc, m_ir); end
        checks++; if (m_ov !== 1'b1 || m_out !== snap) begin errors++; $display("FAIL stall_frozen cyc %0d: valid %b lane %0d changed", cyc, m_ov, diff_lane(m_out, snap)); end
      end
      if (m_iv && m_ir) sent++;
      if (m_ov && m_or) begin
        k = diff_lane(m_out, exp[recv]);
        checks++; if (m_out !== exp[recv] || m_ob !== 1'b0) begin errors++; $display("FAIL stream_data #%0d lane %0d: got %h expected %h", recv, k, m_out[k / 5][k % 5], exp[recv][k / 5][k % 5]); end
        recv++;
      end
    end
    m_iv = 1'b0;
    @(negedge clk);
    checks++; if (recv != 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", recv); end
    checks++; if (m_cnt !== 16'd8) begin errors++; $display("FAIL stream_done_cnt: got %0d expected 8", m_cnt); end
  endtask

  task automatic test_reset_in_flight();
    int n;
    bit stale;
    apply_reset();
    m_or = 1'b1;
    send(rand_state(64), 1'b0);
    wait_out(n);
    @(negedge clk);
    checks++; if (m_cnt !== 16'd1) begin errors++; $display("FAIL flight_pre_cnt: got %0d expected 1", m_cnt); end
    m_or = 1'b0;
    send(rand_state(64), 1'b0);
    send(rand_state(64), 1'b1);
    @(negedge clk);
    checks++; if (m_ir !== 1'b0 || m_ov !== 1'b1) begin errors++; $display("FAIL flight_full: in_ready %b out_valid %b expected 0 1", m_ir, m_ov); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_ov !== 1'b0) begin errors++; $display("FAIL flight_out_valid: got %b expected 0", m_ov); end
    checks++; if (m_cnt !== 16'd0) begin errors++; $display("FAIL flight_done_cnt: got %0d expected 0", m_cnt); end
    checks++; if (m_ir !== 1'b0) begin errors++; $display("FAIL flight_in_ready: got %b expected 0", m_ir); end
    checks++; if (m_out !== '0 || m_ob !== 1'b0) begin errors++; $display("FAIL flight_outputs: lane %0d nonzero expected 0", diff_lane(m_out, '0)); end
    @(negedge clk);
    rst_n = 1'b1;
    m_or  = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m_ov !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale) begin errors++; $display("FAIL flight_stale: got out_valid expected none"); end
    checks++; if (m_cnt !== 16'd0) begin errors++; $display("FAIL flight_post_cnt: got %0d expected 0", m_cnt); end
  endtask

  task automatic test_sweep();
    logic [1600:0] q [4][$];
    logic [1600:0] e;
    int sent [4], recv [4];
    logic [3:0] mcnt [4];
    st64_t o;
    bit all_done;
    int k;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      recv[i] = 0;
      mcnt[i] = 4'd0;
    end
    all_done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !all_done; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        checks++; if (sw_cnt[i] !== mcnt[i]) begin errors++; $display("FAIL sweep_cnt inst %0d: got %0d expected %0d", i, sw_cnt[i], mcnt[i]); end
        sw_iv[i] = (sent[i] < 1000) && ($urandom_range(3) != 0);
        sw_in[i] = rand_state(sw_w[i]);
        sw_ib[i] = ($urandom_range(7) == 0);
        sw_or[i] = ($urandom_range(3) != 0);
      end
      #1;
      all_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (sw_iv[i] && sw_ir[i]) begin
          q[i].push_back({sw_ib[i], model(sw_in[i], sw_ib[i], sw_w[i])});
          sent[i]++;
        end
        if (sw_ov[i] && sw_or[i]) begin
          o = sw_get_out(i);
          e = (q[i].size() > 0) ? q[i].pop_front() : '1;
          k = diff_lane(o, e[1599:0]);
          checks++; if ({sw_ob[i], o} !== e) begin errors++; $display("FAIL sweep_data inst %0d #%0d lane %0d: got %h/%b expected %h/%b", i, recv[i], k, o[k / 5][k % 5], sw_ob[i], e[k * 64 +: 64], e[1600]); end
          recv[i]++;
          mcnt[i] = mcnt[i] + 4'd1;
        end
        if (recv[i] < 1000) all_done = 1'b0;
      end
    end
    sw_iv = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++; if (recv[i] != 1000) begin errors++; $display("FAIL sweep_count inst %0d: got %0d expected 1000", i, recv[i]); end
      checks++; if (sw_cnt[i] !== 4'd8) begin errors++; $display("FAIL sweep_wrap inst %0d: got %0d expected 8", i, sw_cnt[i]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m_iv  = 1'b0;
    m_ib  = 1'b0;
    m_or  = 1'b0;
    m_in  = '0;
    sw_iv = '0;
    sw_ib = '0;
    sw_or = '0;
    for (int i = 0; i < 4; i++) sw_in[i] = '0;
    test_reset();
    test_zero_state();
    test_single_lane(1'b0);
    test_single_lane(1'b1);
    test_stream_stall();
    test_reset_in_flight();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
